// File: rtl/s2qed_inst_dispatch_if.sv
// Instruction-dispatch bundle: source write channel, two fetch ports, lag/sync status.
// The dispatcher takes the slave modport; the harness driving it takes master.
interface s2qed_inst_dispatch_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          src_valid;
    logic [IW-1:0] src_inst;
    logic          src_ready;

    logic          c0_if_req;
    logic          c0_if_ack;
    logic [IW-1:0] c0_if_dr;

    logic          c1_if_req;
    logic          c1_if_ack;
    logic [IW-1:0] c1_if_dr;

    logic [AW:0]   lag;
    logic          sync;

    modport master (
        output src_valid, src_inst, c0_if_req, c1_if_req,
        input  src_ready, c0_if_ack, c0_if_dr, c1_if_ack, c1_if_dr, lag, sync
    );

    modport slave (
        input  src_valid, src_inst, c0_if_req, c1_if_req,
        output src_ready, c0_if_ack, c0_if_dr, c1_if_ack, c1_if_dr, lag, sync
    );
endinterface

// File: rtl/s2qed_inst_dispatch.sv
// Shared instruction buffer serving one stream to two cores through independent read pointers.
// Optional S2QED_REG_REMAP_EN: permutes register fields of selected opcodes on the cpu1 port.
module s2qed_inst_dispatch #(
    parameter int DEPTH = 4,
    parameter int IW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    s2qed_inst_dispatch_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_RESP} port_state_t;

    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   wp_reg;
    logic [AW:0]   rp  [2];
    logic [AW:0]   cnt [2];
    logic          req [2];
    logic          resp[2];
    logic [IW-1:0] dr  [2];
    logic [AW:0]   occ;
    logic          src_ready;
    logic          wr_en;

`ifdef S2QED_REG_REMAP_EN
    function automatic logic [3:0] perm(input logic [3:0] f);
        case (f)
            4'd0:    perm = 4'd0;
            4'd1:    perm = 4'd12;
            4'd2:    perm = 4'd11;
            4'd3:    perm = 4'd10;
            4'd4:    perm = 4'd9;
            4'd5:    perm = 4'd8;
            4'd6:    perm = 4'd7;
            4'd7:    perm = 4'd6;
            4'd8:    perm = 4'd5;
            4'd9:    perm = 4'd4;
            4'd10:   perm = 4'd3;
            4'd11:   perm = 4'd2;
            4'd12:   perm = 4'd13;
            4'd13:   perm = 4'd1;
            4'd14:   perm = 4'd15;
            default: perm = 4'd14;
        endcase
    endfunction

    function automatic logic [IW-1:0] c1_view(input logic [IW-1:0] w);
        logic [IW-1:0] r;
        r = w;
        if (w[15:12] == 4'b0010 || w[15:12] == 4'b0011 || w[15:12] == 4'b0110) begin
            r[11:8] = perm(w[11:8]);
            r[7:4]  = perm(w[7:4]);
        end
        return r;
    endfunction
`else
    function automatic logic [IW-1:0] c1_view(input logic [IW-1:0] w);
        return w;
    endfunction
`endif

    assign req[0] = bus.c0_if_req;
    assign req[1] = bus.c1_if_req;

    // An entry stays occupied until the slower core has fetched it.
    assign occ       = (cnt[0] >= cnt[1]) ? cnt[0] : cnt[1];
    assign src_ready = (occ < DEPTH_P);
    assign wr_en     = bus.src_valid & src_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_reg[AW-1:0]] <= bus.src_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_reg <= '0;
        end else if (wr_en) begin
            wp_reg <= wp_reg + PTR_ONE;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        port_state_t   state_reg;
        logic [AW:0]   rp_reg;
        logic [IW-1:0] dr_reg;
        logic [IW-1:0] rd_word;

        assign rd_word  = mem[rp_reg[AW-1:0]];
        assign cnt[gi]  = wp_reg - rp_reg;
        assign rp[gi]   = rp_reg;
        assign resp[gi] = (state_reg == ST_RESP);
        assign dr[gi]   = dr_reg;

        // ACK is the RESP state itself; requests are ignored while responding.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                rp_reg    <= '0;
                dr_reg    <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (req[gi] && (cnt[gi] != '0)) begin
                            state_reg <= ST_RESP;
                            rp_reg    <= rp_reg + PTR_ONE;
                            dr_reg    <= (gi == 1) ? c1_view(rd_word) : rd_word;
                        end
                    end
                    ST_RESP: state_reg <= ST_IDLE;
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.c0_if_ack = resp[0];
    assign bus.c0_if_dr  = dr[0];
    assign bus.c1_if_ack = resp[1];
    assign bus.c1_if_dr  = dr[1];
    assign bus.lag       = rp[0] - rp[1];
    assign bus.sync      = (rp[0] == rp[1]) & ~resp[0] & ~resp[1];
endmodule
